// File: rtl/sha256_msg_sched_if.sv
// sha256_msg_sched_if: block-in / word-out handshake bundle for the SHA-256
// message scheduler.
//   blk_valid/blk_ready/blk_data : 512-bit block from the padder (W0 = [511:480])
//   w_valid/w_ready              : schedule word handshake to the round datapath
//   w_data/w_idx/w_last          : word W[w_idx], index 0..63, last-word flag
// Modports: slave = scheduler side, master = producer/consumer side.
interface sha256_msg_sched_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;

  modport slave (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_data, w_idx, w_last
  );

  modport master (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_data, w_idx, w_last
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: accepts one 512-bit message block and streams the SHA-256
// message schedule W[0..63], one word per w_valid&w_ready handshake.
// W[0..15] come straight from the block; W[16..63] are generated in a sliding
// 16-word window using the lowercase sigma0/sigma1 functions.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset (aborts any block in flight)
//   bus   : sha256_msg_sched_if.slave (block input / word output handshakes)
// Optional feature: define MSG_SCHED_B2B_EN to accept the next block on the
// W63 transfer, giving zero-bubble back-to-back blocks. Without it, blk_ready
// is asserted only in IDLE.
module sha256_msg_sched #(
  parameter int unsigned S0_R0 = 7,
  parameter int unsigned S0_R1 = 18,
  parameter int unsigned S0_SH = 3,
  parameter int unsigned S1_R0 = 17,
  parameter int unsigned S1_R1 = 19,
  parameter int unsigned S1_SH = 10
) (
  input logic               clk,
  input logic               rst_n,
  sha256_msg_sched_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  idx_q, idx_d;
  logic        blk_ready;
  logic        w_valid;
  logic        last_w;
  logic [31:0] w_new;

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, S0_R0) ^ ror(x, S0_R1) ^ (x >> S0_SH);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, S1_R0) ^ ror(x, S1_R1) ^ (x >> S1_SH);
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    for (int unsigned i = 0; i < 16; i++) win_d[i] = win_q[i];
    blk_ready = 1'b0;
    w_valid   = 1'b0;
    last_w    = (idx_q == 6'd63);
    w_new     = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    unique case (state_q)
      IDLE: begin
        blk_ready = 1'b1;
      end
      RUN: begin
        w_valid = 1'b1;
`ifdef MSG_SCHED_B2B_EN
        blk_ready = last_w & bus.w_ready;
`endif
        if (bus.w_ready) begin
          for (int unsigned i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
          win_d[15] = w_new;
          if (last_w) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load overrides the shift: in IDLE it is the only action, and on the
    // W63 transfer (back-to-back mode) the retiring window is discarded anyway.
    if (bus.blk_valid && blk_ready) begin
      for (int unsigned i = 0; i < 16; i++) win_d[i] = bus.blk_data[511 - 32*i -: 32];
      idx_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int unsigned i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int unsigned i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign bus.blk_ready = blk_ready;
  assign bus.w_valid   = w_valid;
  assign bus.w_data    = (state_q == RUN) ? win_q[0] : '0;
  assign bus.w_idx     = idx_q;
  assign bus.w_last    = (state_q == RUN) && last_w;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: scoreboard bench for sha256_msg_sched. Each accepted
// block pushes its 64 reference schedule words; the head of the queue must
// match the DUT outputs every cycle w_valid is high and is popped on transfer.
module tb_sha256_msg_sched;

`ifdef MSG_SCHED_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [5:0]  idx;
    int          kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha256_msg_sched_if bus ();

  sha256_msg_sched #(
    .S0_R0(7), .S0_R1(18), .S0_SH(3),
    .S1_R0(17), .S1_R1(19), .S1_SH(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t         q[$];
  int           n_total = 0;
  int           n_bad   = 0;
  int           n_fire  = 0;
  int           cur_kind = 0;
  bit           acc_seen;
  bit           rnd_ready = 1'b0;
  bit           gap_open  = 1'b0;
  int           gap       = 0;
  int           last_gap  = 99;
  logic [511:0] abc_blk;
  logic [511:0] ones_blk;
  logic [511:0] oth_blk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic push_block(input logic [511:0] blk, input int kind);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) w[i] = m_s1(w[i-2]) + w[i-7] + m_s0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) begin
      e.data = w[i];
      e.idx  = 6'(i);
      e.kind = kind;
      q.push_back(e);
    end
  endtask

  // Called at a falling edge with inputs set; checks outputs, then models the
  // handshakes that the next rising edge will perform.
  task automatic step();
    bit   exp_rdy;
    bit   fire;
    exp_t e;
    if (rnd_ready) bus.w_ready = 1'($urandom_range(0, 1));
    #1;
    exp_rdy = (q.size() == 0) || (B2B && q.size() == 1 && bus.w_ready);
    check("blk_ready", {63'b0, bus.blk_ready}, {63'b0, exp_rdy});
    check("w_valid", {63'b0, bus.w_valid}, {63'b0, q.size() != 0});
    if (q.size() != 0) begin
      check("w_data", {32'b0, bus.w_data}, {32'b0, q[0].data});
      check("w_idx", {58'b0, bus.w_idx}, {58'b0, q[0].idx});
      check("w_last", {63'b0, bus.w_last}, {63'b0, q[0].idx == 6'd63});
    end
    if (gap_open && !bus.w_valid) gap++;
    fire = bus.w_valid && bus.w_ready;
    if (fire && q.size() != 0) begin
      e = q.pop_front();
      n_fire++;
      if (e.kind == 1 && (e.idx == 6'd0 || e.idx == 6'd16))
        check("abc_w0_w16", {32'b0, bus.w_data}, 64'h61626380);
      if (e.kind == 1 && e.idx == 6'd17)
        check("abc_w17", {32'b0, bus.w_data}, 64'h000F0000);
      if (e.kind == 2 && e.idx == 6'd16)
        check("ones_w16", {32'b0, bus.w_data}, 64'h203FFFFC);
      if (e.idx == 6'd63) begin
        gap_open = 1'b1;
        gap      = 0;
      end else if (e.idx == 6'd0 && gap_open) begin
        last_gap = gap;
        gap_open = 1'b0;
      end
    end
    if (bus.blk_valid && bus.blk_ready) begin
      push_block(bus.blk_data, cur_kind);
      acc_seen = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [511:0] d, input int kind);
    int n = 0;
    bus.blk_valid = 1'b1;
    bus.blk_data  = d;
    cur_kind      = kind;
    acc_seen      = 1'b0;
    while (!acc_seen && n < 300) begin
      step();
      n++;
    end
    check("accept", {63'b0, acc_seen}, 64'd1);
    bus.blk_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    check("drain", 64'(q.size()), 64'd0);
    repeat (2) step();
  endtask

  initial begin
    abc_blk  = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    ones_blk = '1;
    for (int i = 0; i < 16; i++) oth_blk[511 - 32*i -: 32] = $urandom();

    rst_n         = 1'b0;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.w_ready   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_blk_ready", {63'b0, bus.blk_ready}, 64'd1);
    check("rst_w_valid", {63'b0, bus.w_valid}, 64'd0);
    check("rst_w_data", {32'b0, bus.w_data}, 64'd0);
    check("rst_w_idx", {58'b0, bus.w_idx}, 64'd0);
    check("rst_w_last", {63'b0, bus.w_last}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // w_ready in IDLE has no effect
    bus.w_ready = 1'b1;
    repeat (3) step();

    // abc block, consumer always ready
    send(abc_blk, 1);
    drain();

    // abc block under random backpressure
    rnd_ready = 1'b1;
    send(abc_blk, 1);
    drain();

    // second block offered during RUN must wait for W63
    send(abc_blk, 1);
    send(oth_blk, 0);
    drain();
    rnd_ready   = 1'b0;
    bus.w_ready = 1'b1;

    // reset in the middle of a block
    send(abc_blk, 1);
    begin
      int n = 0;
      while (q.size() != 0 && q[0].idx != 6'd20 && n < 200) begin
        step();
        n++;
      end
    end
    check("reach_idx20", {58'b0, bus.w_idx}, 64'd20);
    rst_n = 1'b0;
    #1;
    check("midrst_w_valid", {63'b0, bus.w_valid}, 64'd0);
    check("midrst_blk_ready", {63'b0, bus.blk_ready}, 64'd1);
    check("midrst_w_idx", {58'b0, bus.w_idx}, 64'd0);
    q.delete();
    gap_open = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    send(abc_blk, 1);
    drain();

    // back-to-back blocks with full-rate consumer
    last_gap = 99;
    send(oth_blk, 0);
    send(abc_blk, 1);
    drain();
    check("b2b_gap", 64'(last_gap), B2B ? 64'd0 : 64'd1);

    // all-ones block exercises carry wrap
    send(ones_blk, 2);
    drain();

    check("word_count", 64'(n_fire), 64'd532);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
